// File: rtl/ps2_tx_pkg.sv
// rtl/ps2_tx_pkg.sv - shared types and constants for the PS/2 host-to-device command transmitter
// Purpose: FSM state encoding, PS/2 command bytes, default timing, frame/timer helpers.
// Ports: none (package).
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INHIBIT    = 3'd1,
    ST_REQ        = 3'd2,
    ST_WAIT_FIRST = 3'd3,
    ST_SEND       = 3'd4,
    ST_ACK        = 3'd5,
    ST_IDLE_WAIT  = 3'd6,
    ST_ERR        = 3'd7
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;

  // Defaults assume a 50 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_START_TIMEOUT  = 750000;
  localparam int DEF_BIT_TIMEOUT    = 100000;

  localparam int TIMER_W = 20;

  // {stop, odd parity, data}; shifted out LSB first after the start bit.
  function automatic logic [9:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

  // The timer sticks at all-ones instead of wrapping back into a valid count.
  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (&v) ? v : v + TIMER_W'(1);
  endfunction

endpackage

// File: rtl/ps2_command_tx_if.sv
// rtl/ps2_command_tx_if.sv - command byte handshake between a requester and the PS/2 transmitter
// Purpose: valid/ready transfer of one command byte.
// Signals: cmd_data (byte to send), cmd_valid (request), cmd_ready (transmitter idle).
// Modports: master = requester, slave = transmitter.
interface ps2_command_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output cmd_data, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 pad synchronizer and falling-edge detector
// Purpose: bring the asynchronous PS2_CLK/PS2_DAT pad levels into CLOCK_50 and flag clock falls.
// Ports: CLOCK_50, Reset (async, high); clk_in/dat_in raw pads;
//        clk_s/dat_s synchronized levels; fe one-cycle pulse, 3 cycles after a pad clock fall.
module ps2_line_sync (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic fe
);

  logic clk_m;
  logic dat_m;
  logic clk_d;

  // Flops reset to the idle-high line level so leaving reset never looks like a fall.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      clk_m <= 1'b1;
      clk_s <= 1'b1;
      clk_d <= 1'b1;
      dat_m <= 1'b1;
      dat_s <= 1'b1;
      fe    <= 1'b0;
    end else begin
      clk_m <= clk_in;
      clk_s <= clk_m;
      clk_d <= clk_s;
      dat_m <= dat_in;
      dat_s <= dat_m;
      fe    <= clk_d & ~clk_s;
    end
  end

endmodule

// File: rtl/ps2_command_tx.sv
// rtl/ps2_command_tx.sv - PS/2 host-to-device command byte transmitter with open-drain pad control
// Purpose: send one command byte (e.g. 0xED set LEDs, 0xFF reset) to the keyboard.
// Ports: CLOCK_50, Reset (async, high); cmd (slave: cmd_data/cmd_valid/cmd_ready);
//        ps2_clk_in/ps2_dat_in raw pads; ps2_clk_oe/ps2_dat_oe 1 = pull pad low;
//        busy (not idle, blanks the receiver); tx_done/tx_error one-cycle result pulses.
module ps2_command_tx
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int BIT_TIMEOUT    = DEF_BIT_TIMEOUT
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  ps2_command_tx_if.slave  cmd,
  input  logic             ps2_clk_in,
  input  logic             ps2_dat_in,
  output logic             ps2_clk_oe,
  output logic             ps2_dat_oe,
  output logic             busy,
  output logic             tx_done,
  output logic             tx_error
);

  localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(BIT_TIMEOUT - 1);

  ps2_tx_state_t      state;
  logic [TIMER_W-1:0] timer;
  logic [9:0]         shift;
  logic [3:0]         bitcnt;
  logic               ready;
  logic               clk_s;
  logic               dat_s;
  logic               fe;

  assign cmd.cmd_ready = ready;

  ps2_line_sync u_sync (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .clk_s    (clk_s),
    .dat_s    (dat_s),
    .fe       (fe)
  );

  // Timer conventions: it starts at 0 when REQ is entered so a missing device is
  // flagged START_TIMEOUT cycles after REQ; on every fe it restarts at 1 because
  // the fe cycle itself already counts toward BIT_TIMEOUT.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      ready      <= 1'b1;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      timer      <= '0;
      shift      <= '0;
      bitcnt     <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid && ready) begin
            shift      <= make_frame(cmd.cmd_data);
            timer      <= '0;
            bitcnt     <= '0;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b1;
            ready      <= 1'b0;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (timer == INH_LAST) begin
            timer      <= '0;
            ps2_dat_oe <= 1'b1;   // start bit, clock still held low
            state      <= ST_REQ;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        ST_REQ: begin
          ps2_clk_oe <= 1'b0;
          timer      <= sat_inc(timer);
          state      <= ST_WAIT_FIRST;
        end
        ST_WAIT_FIRST: begin
          if (fe) begin
            ps2_dat_oe <= ~shift[0];
            shift      <= {1'b1, shift[9:1]};
            bitcnt     <= 4'd1;
            timer      <= TIMER_W'(1);
            state      <= ST_SEND;
          end else if (timer == START_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            state      <= ST_ERR;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        ST_SEND: begin
          if (fe) begin
            shift  <= {1'b1, shift[9:1]};
            bitcnt <= bitcnt + 4'd1;
            timer  <= TIMER_W'(1);
            // bitcnt==9 means this fe presents the stop bit: release data for the ACK.
            if (bitcnt == 4'd9) begin
              ps2_dat_oe <= 1'b0;
              state      <= ST_ACK;
            end else begin
              ps2_dat_oe <= ~shift[0];
            end
          end else if (timer == BIT_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            state      <= ST_ERR;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        ST_ACK: begin
          if (fe) begin
            timer <= TIMER_W'(1);
            if (!dat_s) begin
              state <= ST_IDLE_WAIT;
            end else begin
              tx_error <= 1'b1;
              state    <= ST_ERR;
            end
          end else if (timer == BIT_LAST) begin
            tx_error <= 1'b1;
            state    <= ST_ERR;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        ST_IDLE_WAIT: begin
          if (clk_s && dat_s) begin
            tx_done <= 1'b1;
            busy    <= 1'b0;
            ready   <= 1'b1;
            state   <= ST_IDLE;
          end else if (timer == BIT_LAST) begin
            tx_error <= 1'b1;
            state    <= ST_ERR;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        ST_ERR: begin
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          ready      <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// tb/tb_ps2_command_tx.sv - directed self-checking bench for ps2_command_tx
module tb_ps2_command_tx;
  import ps2_tx_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       Reset;
  logic       sel;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       dev_clk;
  logic       dev_dat;
  int         cyc = 0;

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  ps2_command_tx_if cmd_a ();
  ps2_command_tx_if cmd_b ();

  assign cmd_a.cmd_data  = cmd_data;
  assign cmd_a.cmd_valid = cmd_valid & ~sel;
  assign cmd_b.cmd_data  = cmd_data;
  assign cmd_b.cmd_valid = cmd_valid & sel;

  logic clk_oe_a, dat_oe_a, busy_a, done_a, err_a;
  logic clk_oe_b, dat_oe_b, busy_b, done_b, err_b;
  logic pad_clk_a, pad_dat_a, pad_clk_b, pad_dat_b;

  // Open-drain pads: low if the host or the device pulls them low.
  assign pad_clk_a = ~clk_oe_a & (sel ? 1'b1 : dev_clk);
  assign pad_dat_a = ~dat_oe_a & (sel ? 1'b1 : dev_dat);
  assign pad_clk_b = ~clk_oe_b & (sel ? dev_clk : 1'b1);
  assign pad_dat_b = ~dat_oe_b & (sel ? dev_dat : 1'b1);

  ps2_command_tx #(.INHIBIT_CYCLES(4), .START_TIMEOUT(50), .BIT_TIMEOUT(100)) dut_a (
    .CLOCK_50   (CLOCK_50),
    .Reset      (Reset),
    .cmd        (cmd_a),
    .ps2_clk_in (pad_clk_a),
    .ps2_dat_in (pad_dat_a),
    .ps2_clk_oe (clk_oe_a),
    .ps2_dat_oe (dat_oe_a),
    .busy       (busy_a),
    .tx_done    (done_a),
    .tx_error   (err_a)
  );

  ps2_command_tx #(.INHIBIT_CYCLES(4), .START_TIMEOUT(50), .BIT_TIMEOUT(30)) dut_b (
    .CLOCK_50   (CLOCK_50),
    .Reset      (Reset),
    .cmd        (cmd_b),
    .ps2_clk_in (pad_clk_b),
    .ps2_dat_in (pad_dat_b),
    .ps2_clk_oe (clk_oe_b),
    .ps2_dat_oe (dat_oe_b),
    .busy       (busy_b),
    .tx_done    (done_b),
    .tx_error   (err_b)
  );

  logic clk_oe, dat_oe, busy, tx_done, tx_error, cmd_ready;
  assign clk_oe    = sel ? clk_oe_b : clk_oe_a;
  assign dat_oe    = sel ? dat_oe_b : dat_oe_a;
  assign busy      = sel ? busy_b   : busy_a;
  assign tx_done   = sel ? done_b   : done_a;
  assign tx_error  = sel ? err_b    : err_a;
  assign cmd_ready = sel ? cmd_b.cmd_ready : cmd_a.cmd_ready;

  int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0, err_cyc = 0;
  always @(negedge CLOCK_50) begin
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (tx_done && tx_error) both_cnt++;
    if (cmd_valid && cmd_ready && !Reset) acc_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int last_fall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic accept(input logic [7:0] d);
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 300 && !cmd_ready; i++) tick();
    chk(tag, {31'd0, cmd_ready}, 32'd1);
  endtask

  // Device model: waits for the host request, then produces nfe clock pulses.
  // bits[k-1] is the released data level seen at the rising edge after fe #k.
  task automatic dev_run(input int nfe, input int half, input logic ack_bit,
                         output logic [9:0] bits, output bit found);
    found = 1'b0;
    bits  = '0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (!clk_oe && dat_oe) found = 1'b1;
      else tick();
    end
    if (found) begin
      repeat (10) tick();
      for (int k = 1; k <= nfe; k++) begin
        if (k == 11) begin
          dev_dat = ack_bit;
          tick();
        end
        dev_clk   = 1'b0;
        last_fall = cyc;
        repeat (half) tick();
        if (k <= 10) bits[k-1] = ~dat_oe;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (half) tick();
      end
    end
  endtask

  logic [9:0] bits;
  bit         found;
  int         d0, e0, a0, n, r;

  initial begin
    Reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
    dev_clk = 1'b1; dev_dat = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_oe",        {30'd0, clk_oe, dat_oe}, 32'd0);
    chk("rst_pulses",    {30'd0, tx_done, tx_error}, 32'd0);
    Reset = 1'b0;
    tick();

    // 1: 0xED, inhibit length, REQ cycle, frame bits, ACK
    d0 = done_cnt; e0 = err_cnt;
    accept(CMD_SET_LED);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (clk_oe && !dat_oe && n < 50) begin n++; tick(); end
    chk("t1_inhibit_len", n, 4);
    n = 0;
    while (clk_oe && dat_oe && n < 10) begin n++; tick(); end
    chk("t1_req_len", n, 1);
    chk("t1_wait_first_oe", {30'd0, clk_oe, dat_oe}, 32'd1);
    dev_run(11, 20, 1'b0, bits, found);
    chk("t1_found", {31'd0, found}, 32'd1);
    chk("t1_bits", {22'd0, bits}, 32'h3ED);
    wait_ready("t1_ready");
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_no_err", err_cnt - e0, 0);

    // 2: 0x00 then 0x01, parity flips
    d0 = done_cnt;
    accept(8'h00);
    dev_run(11, 20, 1'b0, bits, found);
    chk("t2_data_low", {24'd0, bits[7:0]}, 32'h00);
    chk("t2_parity_00", {31'd0, bits[8]}, 32'd1);
    chk("t2_stop_00", {31'd0, bits[9]}, 32'd1);
    wait_ready("t2_ready_00");
    chk("t2_done_00", done_cnt - d0, 1);
    d0 = done_cnt;
    accept(8'h01);
    dev_run(11, 20, 1'b0, bits, found);
    chk("t2_bits_01", {22'd0, bits}, 32'h201);
    wait_ready("t2_ready_01");
    chk("t2_done_01", done_cnt - d0, 1);

    // 3: missing ACK
    d0 = done_cnt; e0 = err_cnt;
    accept(CMD_ECHO);
    dev_run(11, 20, 1'b1, bits, found);
    chk("t3_bits", {22'd0, bits}, 32'h3EE);
    wait_ready("t3_ready");
    chk("t3_err", err_cnt - e0, 1);
    chk("t3_no_done", done_cnt - d0, 0);

    // 4: device never clocks, START_TIMEOUT=50
    e0 = err_cnt;
    accept(CMD_RESET);
    n = 0;
    while (!(clk_oe && dat_oe) && n < 50) begin n++; tick(); end
    r = cyc;
    n = 0;
    while (!tx_error && n < 200) begin n++; tick(); end
    chk("t4_err_seen", {31'd0, tx_error}, 32'd1);
    chk("t4_err_delay", cyc - r, 50);
    chk("t4_oe_released", {30'd0, clk_oe, dat_oe}, 32'd0);
    tick();
    chk("t4_idle", {30'd0, cmd_ready, busy}, 32'd2);
    chk("t4_err_once", err_cnt - e0, 1);

    // 5: device stops after bit 4, BIT_TIMEOUT=30 (fe latency 3 + 30)
    sel = 1'b1;
    tick();
    d0 = done_cnt; e0 = err_cnt;
    accept(8'hA5);
    dev_run(5, 10, 1'b0, bits, found);
    chk("t5_bits", {27'd0, bits[4:0]}, 32'h05);
    n = 0;
    while (err_cnt == e0 && n < 200) begin n++; tick(); end
    chk("t5_err", err_cnt - e0, 1);
    chk("t5_err_delay", err_cyc - last_fall, 33);
    chk("t5_no_done", done_cnt - d0, 0);
    wait_ready("t5_ready");
    sel = 1'b0;
    tick();

    // 6: reset mid-SEND, then one frame despite repeated cmd_valid
    accept(CMD_SET_LED);
    dev_run(5, 20, 1'b0, bits, found);
    chk("t6_mid_send", {30'd0, busy, dat_oe}, 32'd3);
    Reset = 1'b1;
    #2;
    chk("t6_rst_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    Reset = 1'b0;
    tick();
    d0 = done_cnt; a0 = acc_cnt;
    accept(CMD_RESET);
    for (int i = 0; i < 8; i++) begin
      cmd_data  = 8'h00;
      cmd_valid = ~cmd_valid;
      tick();
    end
    cmd_valid = 1'b0;
    dev_run(11, 20, 1'b0, bits, found);
    chk("t6_bits_ff", {22'd0, bits}, 32'h3FF);
    wait_ready("t6_ready");
    repeat (60) tick();
    chk("t6_accepts", acc_cnt - a0, 1);
    chk("t6_done", done_cnt - d0, 1);
    chk("t6_quiet", {29'd0, clk_oe, dat_oe, busy}, 32'd0);

    chk("never_both", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
